load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word memory request at a time from
// the core, performs it against a single-port word-wide data memory and
// reports completion with a one-cycle done pulse. Sub-word stores are done
// as read-modify-write.
module load_store_unit #(
  parameter int N = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;

  logic        r_req_ready;
  logic        r_done;
  logic [31:0] r_rdata;
  logic        r_fault;
  logic        r_mem_we;
  logic [31:0] r_mem_a;
  logic [31:0] r_mem_wd;

  logic        w_fault;
  logic        w_word_store;

  // Select the addressed lane of a memory word and sign/zero-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_BU:   return {24'd0, b};
      F3_HU:   return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Splice the store data into the addressed lane of the old memory word.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3,
                                              input logic [31:0] wdata);
    logic [31:0] m;
    m = word;
    case (f3)
      F3_B: m[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H: m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: m = wdata;
    endcase
    return m;
  endfunction

  // Classify the incoming request: illegal size code, signed-less store,
  // misalignment or an address beyond the data memory.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_fault = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: w_fault = 1'b0;
      F3_H, F3_HU: w_fault = req_addr[0];
      F3_W:        w_fault = |req_addr[1:0];
      default:     w_fault = 1'b1;
    endcase
    if (req_we && req_funct3[2]) w_fault = 1'b1;
    if ((req_addr >> N) != 32'd0) w_fault = 1'b1;
    w_word_store = req_we && (req_funct3 == F3_W);
  end

  // Request FSM; all outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_buf       <= 32'd0;
      r_req_ready <= 1'b1;
      r_done      <= 1'b0;
      r_rdata     <= 32'd0;
      r_fault     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_a     <= 32'd0;
      r_mem_wd    <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees pre-edge values; the defaults below are overridden per state.
      r_req_ready <= 1'b0;
      r_done      <= 1'b0;
      r_rdata     <= 32'd0;
      r_fault     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_a     <= 32'd0;
      r_mem_wd    <= 32'd0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (w_fault) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_fault <= 1'b1;
            end else if (w_word_store) begin
              r_state  <= WRITE;
              r_mem_we <= 1'b1;
              r_mem_a  <= {req_addr[31:2], 2'b00};
              r_mem_wd <= req_wdata;
            end else begin
              r_state <= READ;
              r_mem_a <= {req_addr[31:2], 2'b00};
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        READ: begin
          r_buf <= mem_rd;
          if (r_we) begin
            r_state  <= WRITE;
            r_mem_we <= 1'b1;
            r_mem_a  <= {r_addr[31:2], 2'b00};
            r_mem_wd <= store_merge(mem_rd, r_addr[1:0], r_funct3, r_wdata);
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_rdata <= load_extract(mem_rd, r_addr[1:0], r_funct3);
          end
        end
        WRITE: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign fault     = r_fault;
  // Reset gates the write strobe immediately so an interrupted WRITE never commits.
  assign mem_we    = r_mem_we & ~reset;
  assign mem_a     = r_mem_a;
  assign mem_wd    = r_mem_wd;

endmodule
